// File: rtl/vector_stress_player.sv
// vector_stress_player: stores stimulus vectors in a small memory, replays them to a
// circuit under test for a programmable number of passes, and compacts the sampled
// responses into a MISR signature.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   wr_en/addr/data   vector memory write port (ignored while busy)
//   start             one-cycle run request (ignored while busy or in the done cycle)
//   len, passes       vectors per pass (clamped to DEPTH), pass count (0 means 1)
//   abort             ends a run on the next edge, no done pulse
//   vec / rsp         stimulus driven out / response sampled in
//   busy, done        run in progress / one-cycle completion pulse
//   vec_idx, pass_idx current position in the run
//   signature         MISR state, all-ones at start of a run
//
// Optional feature, enabled by defining VSP_GOLDEN_CHK_EN:
//   golden_sig (in), match (out): at completion, match reports whether the final
//   signature equals golden_sig; cleared by the next accepted start.
module vector_stress_player #(
    parameter int unsigned      VEC_W  = 33,
    parameter int unsigned      RSP_W  = 25,
    parameter int unsigned      DEPTH  = 32,
    parameter int unsigned      SETTLE = 1,
    parameter logic [RSP_W-1:0] POLY   = 25'h0000009,
    localparam int unsigned     AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [VEC_W-1:0] wr_data,
    input  logic             start,
    input  logic [AW:0]      len,
    input  logic [15:0]      passes,
    input  logic             abort,
    output logic [VEC_W-1:0] vec,
    input  logic [RSP_W-1:0] rsp,
`ifdef VSP_GOLDEN_CHK_EN
    input  logic [RSP_W-1:0] golden_sig,
    output logic             match,
`endif
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    vec_idx,
    output logic [15:0]      pass_idx,
    output logic [RSP_W-1:0] signature
);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StCapture,
        StDone
    } state_e;

    localparam logic [AW:0] DepthLen  = (AW+1)'(DEPTH);
    localparam logic [3:0]  SettleEnd = 4'(SETTLE - 1);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [AW-1:0]      vec_idx_q, vec_idx_d;
    logic [15:0]        pass_idx_q, pass_idx_d;
    logic [RSP_W-1:0]   sig_q, sig_d;
    logic [AW:0]        len_q, len_d;
    logic [15:0]        passes_q, passes_d;
    logic [3:0]         cnt_q, cnt_d;

    logic [VEC_W-1:0]   mem [DEPTH];
    logic [VEC_W-1:0]   rd_data;
    logic [RSP_W-1:0]   sig_next;
    logic [AW:0]        vec_nxt;
    logic [16:0]        pass_nxt;

    assign busy = (state_q == StApply) || (state_q == StSettle) || (state_q == StCapture);
    assign done = (state_q == StDone);

    // Vector memory: no reset, writes locked out while a run is active.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[vec_idx_q];

    assign sig_next = {sig_q[RSP_W-2:0], 1'b0} ^ (sig_q[RSP_W-1] ? POLY : '0) ^ rsp;
    assign vec_nxt  = {1'b0, vec_idx_q} + {{AW{1'b0}}, 1'b1};
    assign pass_nxt = {1'b0, pass_idx_q} + 17'd1;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        vec_idx_d  = vec_idx_q;
        pass_idx_d = pass_idx_q;
        sig_d      = sig_q;
        len_d      = len_q;
        passes_d   = passes_q;
        cnt_d      = cnt_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d      = (len > DepthLen) ? DepthLen : len;
                    passes_d   = (passes == 16'd0) ? 16'd1 : passes;
                    vec_idx_d  = '0;
                    pass_idx_d = '0;
                    sig_d      = '1;
                    state_d    = (len == '0) ? StDone : StApply;
                end
            end
            StApply: begin
                vec_d   = rd_data;
                // cnt counts cycles vec has already been stable once SETTLE is entered.
                cnt_d   = 4'd1;
                state_d = (SETTLE == 1) ? StCapture : StSettle;
            end
            StSettle: begin
                if (cnt_q == SettleEnd) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCapture: begin
                sig_d = sig_next;
                if (vec_nxt < len_q) begin
                    vec_idx_d = vec_nxt[AW-1:0];
                    state_d   = StApply;
                end else if (pass_nxt < {1'b0, passes_q}) begin
                    vec_idx_d  = '0;
                    pass_idx_d = pass_nxt[15:0];
                    state_d    = StApply;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides whatever transition was computed above.
        if (abort && busy) begin
            state_d    = StIdle;
            vec_d      = '0;
            sig_d      = sig_q;
            vec_idx_d  = vec_idx_q;
            pass_idx_d = pass_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            vec_q      <= '0;
            vec_idx_q  <= '0;
            pass_idx_q <= '0;
            sig_q      <= '1;
            len_q      <= '0;
            passes_q   <= 16'd1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            vec_idx_q  <= vec_idx_d;
            pass_idx_q <= pass_idx_d;
            sig_q      <= sig_d;
            len_q      <= len_d;
            passes_q   <= passes_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef VSP_GOLDEN_CHK_EN
    logic match_q, match_d;

    always_comb begin
        match_d = match_q;
        if (state_q == StIdle && start) begin
            match_d = 1'b0;
        end
        // Evaluated on the edge entering DONE, so the result is visible with done.
        if (state_d == StDone && state_q != StDone) begin
            match_d = (sig_d == golden_sig);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`endif

    assign vec       = vec_q;
    assign vec_idx   = vec_idx_q;
    assign pass_idx  = pass_idx_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_vector_stress_player.sv
module tb_vector_stress_player;

    localparam int unsigned      VEC_W  = 33;
    localparam int unsigned      RSP_W  = 25;
    localparam int unsigned      DEPTH  = 32;
    localparam int unsigned      SETTLE = 1;
    localparam logic [RSP_W-1:0] POLY   = 25'h0000009;
    localparam int unsigned      AW     = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [VEC_W-1:0] wr_data;
    logic             start;
    logic [AW:0]      len;
    logic [15:0]      passes;
    logic             abort;
    logic [VEC_W-1:0] vec;
    logic [RSP_W-1:0] rsp;
    logic             busy;
    logic             done;
    logic [AW-1:0]    vec_idx;
    logic [15:0]      pass_idx;
    logic [RSP_W-1:0] signature;
`ifdef VSP_GOLDEN_CHK_EN
    logic [RSP_W-1:0] golden_sig;
    logic             match;
`endif

    int errors = 0;
    int checks = 0;

    logic [VEC_W-1:0] mem_model [DEPTH];
    logic [VEC_W-1:0] exp_vec [$];
    logic [RSP_W-1:0] exp_sig [$];

    vector_stress_player #(
        .VEC_W  (VEC_W),
        .RSP_W  (RSP_W),
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE),
        .POLY   (POLY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .len        (len),
        .passes     (passes),
        .abort      (abort),
        .vec        (vec),
        .rsp        (rsp),
`ifdef VSP_GOLDEN_CHK_EN
        .golden_sig (golden_sig),
        .match      (match),
`endif
        .busy       (busy),
        .done       (done),
        .vec_idx    (vec_idx),
        .pass_idx   (pass_idx),
        .signature  (signature)
    );

    always #5 clk = ~clk;

    function automatic logic [RSP_W-1:0] misr(input logic [RSP_W-1:0] s,
                                               input logic [RSP_W-1:0] r);
        logic [RSP_W:0]   w;
        logic [RSP_W-1:0] t;
        w = {s, 1'b0};
        t = w[RSP_W-1:0];
        if (s[RSP_W-1]) t = t ^ POLY;
        return t ^ r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge.
    task automatic wr(input int addr, input logic [VEC_W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        mem_model[addr] = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // One run. co_write: write mem[0] in the start cycle. disturb: write mem[0] and
    // pulse start during the run. gold_mode: 1 golden = model, 2 golden = model but one
    // driven response bit flipped.
    task automatic run(input int n_len, input int n_pass, input bit zero_rsp,
                       input bit disturb, input bit co_write,
                       input logic [VEC_W-1:0] co_data, input int gold_mode);
        int               eff_len;
        int               eff_pass;
        logic [RSP_W-1:0] s;
        logic [RSP_W-1:0] r;
        logic [RSP_W-1:0] rq [$];
        bit               first;
        eff_len  = (n_len > int'(DEPTH)) ? int'(DEPTH) : n_len;
        eff_pass = (n_pass == 0) ? 1 : n_pass;
        if (co_write) mem_model[0] = co_data;
        s = '1;
        for (int p = 0; p < eff_pass; p++) begin
            for (int i = 0; i < eff_len; i++) begin
                exp_vec.push_back(mem_model[i]);
                r = zero_rsp ? '0 : RSP_W'($urandom);
                rq.push_back(r);
                s = misr(s, r);
            end
        end
`ifdef VSP_GOLDEN_CHK_EN
        golden_sig = s;
        if (gold_mode == 2) begin
            rq[rq.size()-1] = rq[rq.size()-1] ^ RSP_W'(1);
            s = '1;
            foreach (rq[k]) s = misr(s, rq[k]);
        end
`endif
        exp_sig.push_back(s);

        @(posedge clk);
        #1;
        len    = (AW+1)'(n_len);
        passes = 16'(n_pass);
        start  = 1'b1;
        if (co_write) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = co_data;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        first = disturb;
        for (int p = 0; p < eff_pass; p++) begin
            for (int i = 0; i < eff_len; i++) begin
                @(posedge clk);
                @(negedge clk);
                chk("vec", 64'(vec), 64'(exp_vec.pop_front()));
                chk("vec_idx", 64'(vec_idx), 64'(i));
                chk("pass_idx", 64'(pass_idx), 64'(p));
                chk("busy_run", 64'(busy), 64'(1));
                chk("done_run", 64'(done), 64'(0));
                rsp = rq.pop_front();
                if (first) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    wr_data = ~mem_model[0];
                    start   = 1'b1;
                end
                @(posedge clk);
                #1;
                wr_en = 1'b0;
                start = 1'b0;
                first = 1'b0;
                repeat (SETTLE - 1) @(posedge clk);
            end
        end
        @(negedge clk);
        s = exp_sig.pop_front();
        chk("done_pulse", 64'(done), 64'(1));
        chk("busy_done", 64'(busy), 64'(0));
        chk("signature", 64'(signature), 64'(s));
`ifdef VSP_GOLDEN_CHK_EN
        if (gold_mode != 0) chk("match", 64'(match), 64'(gold_mode == 1));
`endif
        @(posedge clk);
        @(negedge clk);
        chk("done_single", 64'(done), 64'(0));
        chk("sig_hold", 64'(signature), 64'(s));
        #1;
    endtask

    initial begin
        logic [RSP_W-1:0] r_ab;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        len     = '0;
        passes  = '0;
        abort   = 1'b0;
        rsp     = '0;
`ifdef VSP_GOLDEN_CHK_EN
        golden_sig = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vec", 64'(vec), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_vec_idx", 64'(vec_idx), 64'(0));
        chk("rst_pass_idx", 64'(pass_idx), 64'(0));
        chk("rst_sig", 64'(signature), 64'(25'h1FFFFFF));
`ifdef VSP_GOLDEN_CHK_EN
        chk("rst_match", 64'(match), 64'(0));
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int a = 0; a < int'(DEPTH); a++) wr(a, {$urandom, 1'b1});
        wr(0, 33'd1);
        wr(1, 33'd2);
        wr(2, 33'd3);

        // Basic 3-vector run, zero responses, done seven cycles after start.
        run(3, 1, 1'b1, 1'b0, 1'b0, '0, 0);
        // Multi-pass with wrap.
        run(2, 3, 1'b0, 1'b0, 1'b0, '0, 0);
        // Empty run.
        run(0, 1, 1'b0, 1'b0, 1'b0, '0, 0);

        // Abort on the third busy cycle.
        r_ab = RSP_W'($urandom);
        @(posedge clk);
        #1;
        len    = 3;
        passes = 1;
        rsp    = r_ab;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_vec", 64'(vec), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_sig", 64'(signature), 64'(misr('1, r_ab)));
        chk("abort_vec_idx", 64'(vec_idx), 64'(1));
        chk("abort_pass_idx", 64'(pass_idx), 64'(0));
        @(negedge clk);
        chk("abort_no_done", 64'(done), 64'(0));
        #1;
        // Abort in IDLE is a no-op.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_sig", 64'(signature), 64'(misr('1, r_ab)));
        @(posedge clk);
        #1;

        // Normal run after abort.
        run(3, 1, 1'b0, 1'b0, 1'b0, '0, 0);
        // Write and start while busy are ignored; rerun still sees old mem[0].
        run(2, 1, 1'b0, 1'b1, 1'b0, '0, 0);
        run(2, 1, 1'b0, 1'b0, 1'b0, '0, 0);
        // Write and start together in IDLE: new mem[0] is used.
        run(2, 1, 1'b0, 1'b0, 1'b1, 33'h1_2345_6789, 0);
        // len above DEPTH clamps, passes = 0 means one pass.
        run(40, 0, 1'b0, 1'b0, 1'b0, '0, 0);
`ifdef VSP_GOLDEN_CHK_EN
        run(3, 1, 1'b0, 1'b0, 1'b0, '0, 1);
        run(3, 1, 1'b0, 1'b0, 1'b0, '0, 2);
`endif

        // Reset mid-run discards it without a done pulse.
        @(posedge clk);
        #1;
        len    = 3;
        passes = 2;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_vec", 64'(vec), 64'(0));
        chk("mid_rst_sig", 64'(signature), 64'(25'h1FFFFFF));
        chk("mid_rst_vec_idx", 64'(vec_idx), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("mid_rst_no_done", 64'(done), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
